// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch buffer: default widths, FSM
// state encoding and the {addr, data} layout of a buffered entry.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 32;
  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned DEPTH_DEFAULT  = 4;
  localparam int unsigned PERF_W         = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  // A buffered entry is {addr, data}: the fetch address sits in the upper bits.
  function automatic int unsigned entry_w(input int unsigned addr_w,
                                          input int unsigned data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order DEPTH-entry synchronous FIFO with clear, count and same-cycle
// push+pop. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset here only because the head output must read zero out of reset; it is tiny.
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Fetch stage: issues one instruction read at a time, buffers returned words
// tagged with their address, and hands them to decode. Optional stall counter
// is enabled by defining FETCH_PERF_COUNTERS_EN.
module instruction_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] currentAddress,
  output logic              pcAdvance,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memGnt,
  input  logic              memRdValid,
  input  logic [DATA_W-1:0] memRdData,
  input  logic              flush,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [PERF_W-1:0] stallCycles,
`endif
  output logic              instrValid,
  output logic [DATA_W-1:0] instrData,
  output logic [ADDR_W-1:0] instrAddr,
  input  logic              instrReady
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = entry_w(ADDR_W, DATA_W);

  fetch_state_e       state;
  fetch_state_e       state_next;
  logic               drop;
  logic               drop_next;
  logic [ADDR_W-1:0]  req_addr;
  logic [ADDR_W-1:0]  req_addr_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     count_after;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ENTRY_W-1:0] head;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (fifo_push),
    .push_data ({req_addr, memRdData}),
    .pop       (fifo_pop),
    .head_data (head),
    .count     (count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign instrValid = ~fifo_empty;
  assign fifo_pop   = instrValid & instrReady;
  assign instrAddr  = head[ENTRY_W-1 -: ADDR_W];
  assign instrData  = head[DATA_W-1:0];
  assign pcAdvance  = memReq & memGnt;
  assign memAddr    = memReq ? currentAddress : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      drop     <= 1'b0;
      req_addr <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state    <= state_next;
      drop     <= drop_next;
      req_addr <= req_addr_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    state_next    = state;
    drop_next     = drop;
    req_addr_next = req_addr;
    memReq        = 1'b0;
    fifo_push     = 1'b0;
    count_after   = '0;
    case (state)
      IDLE: begin
        if (!flush && !fifo_full) state_next = REQ;
      end
      REQ: begin
        memReq = 1'b1;
        if (memGnt) begin
          req_addr_next = currentAddress;
          // A read granted alongside a flush belongs to the old stream.
          drop_next     = flush;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        if (memRdValid) begin
          fifo_push   = ~drop & ~flush;
          drop_next   = 1'b0;
          count_after = {1'b0, count} + (CNT_W + 1)'(fifo_push)
                        - (CNT_W + 1)'(fifo_pop);
          if (flush || count_after < (CNT_W + 1)'(DEPTH)) state_next = REQ;
          else                                            state_next = IDLE;
        end else if (flush) begin
          drop_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FETCH_PERF_COUNTERS_EN
  // Cycles where decode was ready but had nothing to take; saturating.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stallCycles <= '0;
    end else if (instrReady && !instrValid && stallCycles != '1) begin
      stallCycles <= stallCycles + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Directed bench for instruction_fetch_buffer: scoreboard of {addr, data}
// entries checked as decode consumes them, plus cycle-level protocol checks.
module tb_instruction_fetch_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] currentAddress;
  logic        pcAdvance;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt;
  logic        memRdValid;
  logic [31:0] memRdData;
  logic        flush;
  logic        instrValid;
  logic [31:0] instrData;
  logic [31:0] instrAddr;
  logic        instrReady;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stallCycles;
  logic [31:0] exp_stall;
`endif

  int          total = 0;
  int          bad   = 0;
  int          pc_pulses = 0;
  int          pops = 0;
  bit          toggle_ready = 0;
  logic [63:0] sb[$];

  instruction_fetch_buffer #(
    .ADDR_W (32),
    .DATA_W (32),
    .DEPTH  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .currentAddress (currentAddress),
    .pcAdvance      (pcAdvance),
    .memReq         (memReq),
    .memAddr        (memAddr),
    .memGnt         (memGnt),
    .memRdValid     (memRdValid),
    .memRdData      (memRdData),
    .flush          (flush),
`ifdef FETCH_PERF_COUNTERS_EN
    .stallCycles    (stallCycles),
`endif
    .instrValid     (instrValid),
    .instrData      (instrData),
    .instrAddr      (instrAddr),
    .instrReady     (instrReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_ready) instrReady = ~instrReady;
  endtask

  // Drive one complete fetch: wait for a request, grant it, return data after gap cycles.
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d,
                           input int gap, input bit expect_push);
    currentAddress = a;
    #1;
    for (int i = 0; i < 20 && !memReq; i++) tick();
    check("req_seen", memReq, 1'b1);
    if (!memReq) return;
    check("mem_addr", memAddr, a);
    memGnt = 1'b1;
    #1;
    check("pc_advance_on_gnt", pcAdvance, 1'b1);
    tick();
    memGnt = 1'b0;
    repeat (gap) tick();
    memRdValid = 1'b1;
    memRdData  = d;
    if (expect_push) sb.push_back({a, d});
    tick();
    memRdValid = 1'b0;
  endtask

  // Consumer side of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (pcAdvance) pc_pulses++;
      if (instrValid && instrReady) begin
        pops++;
        if (sb.size() == 0) check("unexpected_instr", {instrAddr, instrData}, 64'hx);
        else                check("instr_head", {instrAddr, instrData}, sb.pop_front());
      end
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  always @(posedge clk) begin
    if (!rst) exp_stall <= '0;
    else if (instrReady && !instrValid && exp_stall != 32'hFFFF_FFFF) exp_stall <= exp_stall + 32'd1;
  end
`endif

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int pops_before;
    rst = 1'b0; currentAddress = '0; memGnt = 1'b1; memRdValid = 1'b0;
    memRdData = '0; flush = 1'b0; instrReady = 1'b0;

    // Reset with a grant pending on the bus.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_memreq", memReq, 1'b0);
      check("rst_valid", instrValid, 1'b0);
      check("rst_pcadv", pcAdvance, 1'b0);
    end
    check("rst_head", {instrAddr, instrData}, 64'h0);
    rst = 1'b1;
    memGnt = 1'b0;
    #1;
    check("idle_after_rst", memReq, 1'b0);
    tick();
    check("req_after_rst", memReq, 1'b1);

    // Single fetch: grant cycle, one wait cycle, data, valid next cycle.
    currentAddress = 32'h00F9_CAEE;
    memGnt = 1'b1;
    #1;
    check("single_pcadv", pcAdvance, 1'b1);
    check("single_addr", memAddr, 32'h00F9_CAEE);
    tick();
    memGnt = 1'b0;
    #1;
    check("single_wait_noreq", memReq, 1'b0);
    check("single_pcadv_off", pcAdvance, 1'b0);
    tick();
    memRdValid = 1'b1; memRdData = 32'h1234_5678;
    sb.push_back({32'h00F9_CAEE, 32'h1234_5678});
    #1;
    check("single_not_yet", instrValid, 1'b0);
    tick();
    memRdValid = 1'b0;
    check("single_valid", instrValid, 1'b1);
    check("single_iaddr", instrAddr, 32'h00F9_CAEE);
    check("single_idata", instrData, 32'h1234_5678);
    check("single_rereq", memReq, 1'b1);
    instrReady = 1'b1;
    tick();
    instrReady = 1'b0;
    check("single_drained", instrValid, 1'b0);

    // Fill to DEPTH under backpressure.
    pc_pulses = 0;
    pops_before = pops;
    for (int i = 0; i < 4; i++) fetch_one(32'h100 + 32'(i * 4), 32'hF111_0000 + 32'(i), 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_noreq", memReq, 1'b0);
    end
    check("full_valid", instrValid, 1'b1);
    check("full_pcpulses", pc_pulses, 4);
    instrReady = 1'b1;
    tick();
    instrReady = 1'b0;
    check("one_pop", pops - pops_before, 1);
    tick();
    check("rereq_after_pop", memReq, 1'b1);
    instrReady = 1'b1;
    repeat (4) tick();
    instrReady = 1'b0;
    check("fill_pops", pops - pops_before, 4);
    check("fill_empty", instrValid, 1'b0);

    // Ordering and pointer wrap with toggling ready.
    pops_before = pops;
    toggle_ready = 1'b1;
    for (int i = 0; i < 8; i++) fetch_one(32'(i * 4), 32'hC0DE_0000 | 32'(i), 1, 1'b1);
    toggle_ready = 1'b0;
    instrReady = 1'b1;
    repeat (8) tick();
    check("wrap_pops", pops - pops_before, 8);
    check("wrap_sb_empty", sb.size(), 0);

    // Flush while a read is outstanding.
    instrReady = 1'b0;
    fetch_one(32'h200, 32'hAAAA_0001, 1, 1'b1);
    fetch_one(32'h204, 32'hAAAA_0002, 1, 1'b1);
    currentAddress = 32'h208;
    for (int i = 0; i < 20 && !memReq; i++) tick();
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    check("pre_flush_valid", instrValid, 1'b1);
    flush = 1'b1;
    sb.delete();
    tick();
    flush = 1'b0;
    check("flush_valid", instrValid, 1'b0);
    currentAddress = 32'hFFF9_CAEE;
    tick();
    memRdValid = 1'b1; memRdData = 32'hDEAD_BEEF;
    tick();
    memRdValid = 1'b0;
    check("flush_dropped", instrValid, 1'b0);
    check("flush_rereq", memReq, 1'b1);
    check("flush_redirect", memAddr, 32'hFFF9_CAEE);
    // Stray read data outside WAIT.
    memRdValid = 1'b1; memRdData = 32'h5555_5555;
    tick();
    memRdValid = 1'b0;
    check("stray_ignored", instrValid, 1'b0);
    fetch_one(32'hFFF9_CAEE, 32'h0BAD_F00D, 1, 1'b1);
    instrReady = 1'b1;
    repeat (3) tick();
    check("flush_sb_empty", sb.size(), 0);
    check("flush_drained", instrValid, 1'b0);

`ifdef FETCH_PERF_COUNTERS_EN
    // Slow memory with decode always ready.
    fetch_one(32'h300, 32'h7777_0000, 5, 1'b1);
    repeat (3) tick();
    check("stall_count", stallCycles, exp_stall);
    check("stall_nonzero", exp_stall != 32'd0, 1'b1);
`endif

    // Reset while a read is outstanding; its late data must vanish.
    instrReady = 1'b0;
    currentAddress = 32'h400;
    for (int i = 0; i < 20 && !memReq; i++) tick();
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    rst = 1'b0;
    sb.delete();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_noreq", memReq, 1'b0);
    memRdValid = 1'b1; memRdData = 32'h6666_6666;
    tick();
    memRdValid = 1'b0;
    tick();
    check("midrst_late_ignored", instrValid, 1'b0);
    check("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
